pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It produces per-register enables and flushes for three cases: load-use stalls, taken-branch flushes and multi-cycle multiply/divide occupancy of EX. It also keeps an optional stall-cycle performance counter. It sits beside the pipeline registers, and each register samples its enable/flush pair at its own capture edge.

---
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stalls, taken-branch squashes, multi-cycle MDU occupancy.
// Outputs are combinational from state and inputs. Optional stall counter under PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int REGW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic            ex_mem_read,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_branch_taken,
  input  logic            ex_mdu_start,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            ex_mem_en,
  output logic            mem_wb_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            ex_mem_flush,
  output logic            mdu_busy,
  output logic [15:0]     stall_cnt
);

  typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} state_e;

  // Start cycle and release cycle bracket the MDU_WAIT countdown.
  localparam logic [7:0] CNT_INIT = 8'(MDU_LAT - 2);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       load_use;
  logic       mdu_stall;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  assign mdu_stall = ((state_q == MDU_WAIT) && (cnt_q != 8'd0)) ||
                     ((state_q == RUN) && !ex_branch_taken && ex_mdu_start);

  assign mdu_busy = (state_q == MDU_WAIT);

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (mdu_stall) begin
      // Freeze the front end; a bubble enters MEM while older work drains.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (state_q == RUN) begin
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (!ex_branch_taken && ex_mdu_start) begin
            state_q <= MDU_WAIT;
            cnt_q   <= CNT_INIT;
          end
        end
        MDU_WAIT: begin
          if (cnt_q != 8'd0) cnt_q   <= cnt_q - 8'd1;
          else               state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (!pc_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a cycle-budget model.
module tb_pipe_hazard_ctrl;
  localparam int MDU_LAT = 32;
  localparam int REGW    = 5;
  localparam logic [7:0] O_RESET  = 8'b00000_111;
  localparam logic [7:0] O_NORMAL = 8'b11111_000;
  localparam logic [7:0] O_STALL  = 8'b00011_001;
  localparam logic [7:0] O_LOAD   = 8'b00111_010;
  localparam logic [7:0] O_BRANCH = 8'b11111_110;

  logic clk = 1'b0;
  logic rst_n;
  logic [REGW-1:0] id_rs, id_rt, ex_rd;
  logic id_uses_rt, ex_mem_read, ex_branch_taken, ex_mdu_start;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mdu_busy;
  logic [15:0] stall_cnt;
  logic [7:0] outs;

  int n_checks = 0;
  int n_fail   = 0;
  // Model: remaining MDU_WAIT cycles (last one is the release) and stall cycles seen.
  int m_busy_left = 0;
  int m_stalls    = 0;

  always #5 clk = ~clk;

  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, ex_mem_flush};

  pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_mdu_start(ex_mdu_start), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt)
  );

  function automatic logic [7:0] model_outs();
    logic hit;
    hit = ex_mem_read && (ex_rd != 0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    if (!rst_n)            return O_RESET;
    if (m_busy_left > 1)   return O_STALL;
    if (m_busy_left == 1)  return O_NORMAL;
    if (ex_branch_taken)   return O_BRANCH;
    if (ex_mdu_start)      return O_STALL;
    if (hit)               return O_LOAD;
    return O_NORMAL;
  endfunction

  function automatic logic [15:0] model_cnt();
`ifdef PIPE_HAZARD_PERF_EN
    return rst_n ? 16'(m_stalls) : 16'd0;
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic model_busy();
    return rst_n && (m_busy_left > 0);
  endfunction

  task automatic tick();
    logic [7:0] e;
    int nb, ns;
    e = model_outs();
    if (!rst_n) begin
      nb = 0; ns = 0;
    end else begin
      ns = m_stalls + (e[7] ? 0 : 1);
      if (ns > 65535) ns = 65535;
      if (m_busy_left > 0) nb = m_busy_left - 1;
      else if (!ex_branch_taken && ex_mdu_start) nb = MDU_LAT - 1;
      else nb = 0;
    end
    @(posedge clk);
    m_busy_left = nb;
    m_stalls    = ns;
    #1;
  endtask

  task automatic drive_idle();
    id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rt = 0;
    ex_mem_read = 0; ex_branch_taken = 0; ex_mdu_start = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      id_rs = REGW'($urandom); id_rt = REGW'($urandom); ex_rd = REGW'($urandom);
      id_uses_rt = 1'($urandom); ex_mem_read = 1'($urandom);
      ex_branch_taken = 1'($urandom); ex_mdu_start = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (outs !== O_RESET || mdu_busy !== 1'b0 || stall_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_hold: outs=%b busy=%b cnt=%0d, want outs=%b busy=0 cnt=0",
                 outs, mdu_busy, stall_cnt, O_RESET);
      end
      tick();
    end
    rst_n = 1'b1;
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (outs !== O_NORMAL || mdu_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: outs=%b busy=%b, want outs=%b busy=0", outs, mdu_busy, O_NORMAL);
    end
    tick();
  endtask

  task automatic test_load_use();
    // Each row: rs, rt, uses_rt, ex_rd, expected pattern
    logic [REGW-1:0] rs [4] = '{5'd8, 5'd0, 5'd3, 5'd3};
    logic [REGW-1:0] rt [4] = '{5'd1, 5'd0, 5'd8, 5'd8};
    logic            ur [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [REGW-1:0] rd [4] = '{5'd8, 5'd0, 5'd8, 5'd8};
    logic [7:0]      ex [4] = '{O_LOAD, O_NORMAL, O_NORMAL, O_LOAD};
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      id_rs = rs[i]; id_rt = rt[i]; id_uses_rt = ur[i]; ex_rd = rd[i]; ex_mem_read = 1'b1;
      @(negedge clk);
      n_checks++;
      if (outs !== ex[i]) begin
        n_fail++;
        $display("FAIL load_use_%0d: outs=%b, want %b", i, outs, ex[i]);
      end
      tick();
      // Bubble now sits in EX; the stall must not repeat.
      ex_mem_read = 1'b0; ex_rd = 0;
      @(negedge clk);
      n_checks++;
      if (outs !== O_NORMAL) begin
        n_fail++;
        $display("FAIL load_use_after_%0d: outs=%b, want %b", i, outs, O_NORMAL);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    drive_idle();
    ex_branch_taken = 1'b1; ex_mdu_start = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    n_checks++;
    if (outs !== O_BRANCH) begin
      n_fail++;
      $display("FAIL branch_prio: outs=%b, want %b", outs, O_BRANCH);
    end
    tick();
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (mdu_busy !== 1'b0 || outs !== O_NORMAL) begin
      n_fail++;
      $display("FAIL branch_no_mdu: busy=%b outs=%b, want busy=0 outs=%b", mdu_busy, outs, O_NORMAL);
    end
    tick();
  endtask

  task automatic test_mdu();
    int stalls, busy;
    rst_n = 1'b0; drive_idle(); tick(); rst_n = 1'b1;
    ex_mdu_start = 1'b1;
    stalls = 0; busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pc_en === 1'b1) break;
      stalls++;
      if (mdu_busy === 1'b1) busy++;
      tick();
    end
    n_checks++;
    if (stalls !== MDU_LAT - 1 || busy !== MDU_LAT - 2) begin
      n_fail++;
      $display("FAIL mdu_stall_len: stalls=%0d busy=%0d, want %0d and %0d", stalls, busy, MDU_LAT - 1, MDU_LAT - 2);
    end
    n_checks++;
    if (outs !== O_NORMAL || mdu_busy !== 1'b1 || stall_cnt !== model_cnt()) begin
      n_fail++;
      $display("FAIL mdu_release: outs=%b busy=%b cnt=%0d, want outs=%b busy=1 cnt=%0d",
               outs, mdu_busy, stall_cnt, O_NORMAL, model_cnt());
    end
`ifdef PIPE_HAZARD_PERF_EN
    n_checks++;
    if (stall_cnt !== 16'd31) begin
      n_fail++;
      $display("FAIL mdu_perf: stall_cnt=%0d, want 31", stall_cnt);
    end
`endif
    tick();
    ex_mdu_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mdu_busy !== 1'b0 || outs !== O_NORMAL) begin
      n_fail++;
      $display("FAIL mdu_done: busy=%b outs=%b, want busy=0 outs=%b", mdu_busy, outs, O_NORMAL);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int stalls;
    drive_idle();
    ex_mdu_start = 1'b1;
    tick();
    repeat (20) tick();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs !== O_RESET || mdu_busy !== 1'b0 || stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid: outs=%b busy=%b cnt=%0d, want outs=%b busy=0 cnt=0",
               outs, mdu_busy, stall_cnt, O_RESET);
    end
    tick();
    rst_n = 1'b1;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pc_en === 1'b1) break;
      stalls++;
      tick();
    end
    n_checks++;
    if (stalls !== MDU_LAT - 1) begin
      n_fail++;
      $display("FAIL reset_mid_restart: stalls=%0d, want %0d", stalls, MDU_LAT - 1);
    end
    tick();
    ex_mdu_start = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(63) != 0);
      id_rs = REGW'($urandom_range(3)); id_rt = REGW'($urandom_range(3));
      ex_rd = REGW'($urandom_range(3)); id_uses_rt = 1'($urandom);
      ex_mem_read = ($urandom_range(2) == 0);
      ex_branch_taken = ($urandom_range(7) == 0);
      ex_mdu_start = (m_busy_left > 0) ? 1'b1 : ($urandom_range(15) == 0);
      @(negedge clk);
      n_checks++;
      if (outs !== model_outs() || mdu_busy !== model_busy() || stall_cnt !== model_cnt()) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random_%0d: outs=%b busy=%b cnt=%0d, want outs=%b busy=%b cnt=%0d",
                   i, outs, mdu_busy, stall_cnt, model_outs(), model_busy(), model_cnt());
        bad++;
      end
      tick();
    end
    rst_n = 1'b1; drive_idle();
    repeat (MDU_LAT + 2) tick();
  endtask

`ifdef PIPE_HAZARD_PERF_EN
  task automatic test_saturation();
    rst_n = 1'b0; drive_idle(); tick(); rst_n = 1'b1;
    ex_mdu_start = 1'b1;
    repeat (72500) tick();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 16'hFFFF || stall_cnt !== model_cnt()) begin
      n_fail++;
      $display("FAIL saturate: stall_cnt=%h, want FFFF", stall_cnt);
    end
    repeat (40) tick();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturate_hold: stall_cnt=%h, want FFFF", stall_cnt);
    end
    ex_mdu_start = 1'b0;
    repeat (MDU_LAT + 2) tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_load_use();
    test_branch();
    test_mdu();
    test_reset_mid();
    test_random();
`ifdef PIPE_HAZARD_PERF_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
